// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : PC / fetch stage with IF/ID register, redirects, stall and fault halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jump_reg,
   input  logic [31:0] jr_target,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        pc_fault
);

   // 33 bits so a full 4 GiB memory does not wrap the limit to zero
   localparam logic [32:0] c_limit = 33'(IMEM_WORDS) * 33'd4;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_instr;
   logic [31:0] w_instr_next;
   logic [31:0] r_instr_pc;
   logic [31:0] w_instr_pc_next;
   logic        r_instr_valid;
   logic        w_instr_valid_next;
   logic        r_fault;
   logic        w_fault_next;

   logic        w_redirect;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;
   logic [31:0] w_cand;
   logic        w_fault;

   assign imem_address = r_pc;
   assign instr        = r_instr;
   assign instr_pc     = r_instr_pc;
   assign pc_plus4     = w_pc_plus4;
   assign instr_valid  = r_instr_valid;
   assign pc_fault     = r_fault;

   assign w_pc_plus4 = r_instr_pc + 32'd4;
   // A redirect belongs to the instruction in IF/ID, so a bubble cannot redirect
   assign w_redirect = r_instr_valid & (jump_reg | jump | branch_taken);

   always_comb begin
      w_target = w_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
      if (jump_reg) begin
         w_target = {jr_target[31:2], 2'b00};
      end else if (jump) begin
         w_target = {w_pc_plus4[31:28], jump_target, 2'b00};
      end
   end

   always_comb begin
      w_cand = r_pc + 32'd4;
      if (w_redirect) begin
         w_cand = w_target;
      end else if (stall) begin
         w_cand = r_pc;
      end
   end

   assign w_fault = (w_redirect & jump_reg & (|jr_target[1:0])) |
                    ({1'b0, w_cand} >= c_limit);

   always_comb begin
      w_state_next       = r_state;
      w_pc_next          = r_pc;
      w_instr_next       = r_instr;
      w_instr_pc_next    = r_instr_pc;
      w_instr_valid_next = r_instr_valid;
      w_fault_next       = r_fault;
      case (r_state)
         ST_RUN: begin
            if (w_fault) begin
               w_state_next       = ST_FAULT;
               w_fault_next       = 1'b1;
               w_pc_next          = {w_cand[31:2], 2'b00};
               w_instr_valid_next = 1'b0;
            end else if (w_redirect) begin
               w_pc_next          = w_cand;
               w_instr_valid_next = 1'b0;
            end else if (!stall) begin
               w_instr_next       = imem_data;
               w_instr_pc_next    = r_pc;
               w_instr_valid_next = 1'b1;
               w_pc_next          = w_cand;
            end
         end
         ST_FAULT: begin
            w_instr_valid_next = 1'b0;
         end
         default: begin
            w_state_next = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pc          <= w_pc_next;
         r_instr       <= w_instr_next;
         r_instr_pc    <= w_instr_pc_next;
         r_instr_valid <= w_instr_valid_next;
         r_fault       <= w_fault_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed + random bench for instruction_fetch against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = '0;
   logic        jump_reg = 1'b0;
   logic [31:0] jr_target = '0;

   logic [31:0] imem_address, imem_data, instr, instr_pc, pc_plus4;
   logic        instr_valid, pc_fault;
   logic [31:0] d2_addr, d2_data, d2_instr, d2_ipc, d2_p4;
   logic        d2_valid, d2_fault;

   logic [31:0] mem [0:1023];
   int          errors = 0;
   int          checks = 0;
   logic        cmp_en = 1'b0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_address[11:2]];
   assign d2_data   = mem[d2_addr[11:2]];

   instruction_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
      .clk(clk), .reset_n(reset_n), .imem_address(imem_address), .imem_data(imem_data),
      .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg), .jr_target(jr_target),
      .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
      .instr_valid(instr_valid), .pc_fault(pc_fault)
   );

   instruction_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut2 (
      .clk(clk), .reset_n(reset_n), .imem_address(d2_addr), .imem_data(d2_data),
      .stall(1'b0), .branch_taken(1'b0), .branch_offset(16'h0),
      .jump(1'b0), .jump_target(26'h0), .jump_reg(1'b0), .jr_target(32'h0),
      .instr(d2_instr), .instr_pc(d2_ipc), .pc_plus4(d2_p4),
      .instr_valid(d2_valid), .pc_fault(d2_fault)
   );

   // Reference model: architectural state only
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        valid;
      logic        fault;
   } ms_t;

   localparam ms_t c_rst = '{pc: 32'h0, instr: 32'h0, ipc: 32'h0, valid: 1'b0, fault: 1'b0};

   function automatic ms_t step(ms_t s, logic [31:0] data, logic st, logic br, logic [15:0] off,
                                logic j, logic [25:0] jt, logic jr, logic [31:0] jrt, longint limit);
      ms_t         n = s;
      logic [31:0] p4, tgt, newpc;
      logic        redirect, bad;
      if (s.fault) return s;
      p4       = s.ipc + 32'd4;
      redirect = s.valid && (jr || j || br);
      if (jr)     tgt = {jrt[31:2], 2'b00};
      else if (j) tgt = {p4[31:28], jt, 2'b00};
      else        tgt = p4 + 32'(int'($signed(off)) * 4);
      newpc = redirect ? tgt : (st ? s.pc : s.pc + 32'd4);
      bad   = (redirect && jr && jrt[1:0] != 2'b00) || (longint'(newpc) >= limit);
      if (bad) begin
         n.fault = 1'b1;
         n.pc    = {newpc[31:2], 2'b00};
         n.valid = 1'b0;
      end else if (redirect) begin
         n.pc    = tgt;
         n.valid = 1'b0;
      end else if (!st) begin
         n.instr = data;
         n.ipc   = s.pc;
         n.valid = 1'b1;
         n.pc    = s.pc + 32'd4;
      end
      return n;
   endfunction

   ms_t m1, m2;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m1 <= c_rst;
         m2 <= c_rst;
      end else begin
         m1 <= step(m1, mem[m1.pc[11:2]], stall, branch_taken, branch_offset,
                    jump, jump_target, jump_reg, jr_target, 64'd4096);
         m2 <= step(m2, mem[m2.pc[11:2]], 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 64'd16);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("pc",          imem_address,       m1.pc);
         check("instr",       instr,              m1.instr);
         check("instr_pc",    instr_pc,           m1.ipc);
         check("pc_plus4",    pc_plus4,           m1.ipc + 32'd4);
         check("instr_valid", 32'(instr_valid),   32'(m1.valid));
         check("pc_fault",    32'(pc_fault),      32'(m1.fault));
         check("d2.pc",       d2_addr,            m2.pc);
         check("d2.instr",    d2_instr,           m2.instr);
         check("d2.instr_pc", d2_ipc,             m2.ipc);
         check("d2.pc_plus4", d2_p4,              m2.ipc + 32'd4);
         check("d2.valid",    32'(d2_valid),      32'(m2.valid));
         check("d2.fault",    32'(d2_fault),      32'(m2.fault));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
      #1 reset_n = 1'b0;
      #1 cmp_en = 1'b1;
      tick(); tick();
      check("rst.pc",    imem_address,     32'h0);
      check("rst.valid", 32'(instr_valid), 32'h0);
      check("rst.instr", instr,            32'h0);
      reset_n = 1'b1;

      // sequential fetch
      tick();
      check("seq0.ipc",   instr_pc,         32'h0);
      check("seq0.instr", instr,            32'h1000_0000);
      check("seq0.valid", 32'(instr_valid), 32'h1);
      tick();
      check("seq1.ipc", instr_pc, 32'h4);
      tick();
      check("seq2.ipc",  instr_pc,         32'h8);
      check("d2.ipc8",   d2_ipc,           32'h8);
      check("d2.valid8", 32'(d2_valid),    32'h1);

      // stall 3 cycles; small-memory instance faults on its next step
      stall = 1'b1;
      tick();
      check("d2.fault",     32'(d2_fault), 32'h1);
      check("d2.fault_pc",  d2_addr,       32'h10);
      check("d2.fault_ipc", d2_ipc,        32'h8);
      tick(); tick();
      check("stall.ipc",   instr_pc,     32'h8);
      check("stall.pc",    imem_address, 32'hC);
      check("stall.instr", instr,        32'h1000_0002);
      stall = 1'b0;
      tick();
      check("resume.ipc",   instr_pc, 32'hC);
      check("resume.instr", instr,    32'h1000_0003);
      tick();
      check("pre_br.ipc", instr_pc, 32'h10);

      // backward branch
      branch_taken = 1'b1; branch_offset = 16'hFFFE;
      tick();
      check("br.pc",    imem_address,     32'hC);
      check("br.valid", 32'(instr_valid), 32'h0);
      check("br.ipc",   instr_pc,         32'h10);
      branch_taken = 1'b0;
      tick();
      check("br.next_ipc", instr_pc, 32'hC);

      // jr beats jump, also under stall
      jump_reg = 1'b1; jump = 1'b1; jr_target = 32'h40; jump_target = 26'h3FF;
      tick();
      check("jr.pc", imem_address, 32'h40);
      jump_reg = 1'b0; jump = 1'b0;
      tick();
      check("jr.ipc", instr_pc, 32'h40);
      stall = 1'b1; jump_reg = 1'b1; jr_target = 32'h80;
      tick();
      check("jr_stall.pc", imem_address, 32'h80);
      stall = 1'b0; jump_reg = 1'b0;
      tick();

      // misaligned jr fault, then mid-cycle reset
      jump_reg = 1'b1; jr_target = 32'h42;
      tick();
      check("jrf.fault", 32'(pc_fault),    32'h1);
      check("jrf.pc",    imem_address,     32'h40);
      jump_reg = 1'b0; jump = 1'b1; jump_target = 26'h5;
      tick(); tick();
      check("jrf.hold_pc",    imem_address,     32'h40);
      check("jrf.hold_valid", 32'(instr_valid), 32'h0);
      jump = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst.pc",    imem_address,  32'h0);
      check("arst.fault", 32'(pc_fault), 32'h0);
      tick();
      reset_n = 1'b1;

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         if (m1.fault || ($urandom % 64) == 0) begin
            reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
         stall         = ($urandom % 4) == 0;
         branch_taken  = ($urandom % 5) == 0;
         branch_offset = 16'($urandom_range(0, 40)) - 16'd20;
         jump          = ($urandom % 8) == 0;
         jump_target   = 26'($urandom_range(0, 1023));
         jump_reg      = ($urandom % 8) == 0;
         jr_target     = 32'($urandom_range(0, 1023)) * 32'd4 +
                         ((($urandom % 20) == 0) ? 32'd2 : 32'd0);
         tick();
      end

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
